// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder block.
//   mode_t        : encoding of the 2-bit mode input
//   state_t       : sequencer states
//   presc_width() : prescaler register width for a given DIV
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_SWEEP  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIRECT = 2'b01,
    SCAN   = 2'b10,
    SWEEP  = 2'b11
  } state_t;

  // One spare bit over the minimum so DIV = 1 still yields a 1-bit counter.
  function automatic int unsigned presc_width(input int unsigned div);
    return $clog2(div) + 1;
  endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational N -> 2^N one-hot decoder, reversed bit order, active-low enable.
//   idx  : index to decode (k asserts o[2^N-1-k], so k = 0 drives the MSB)
//   en_n : active-low enable; high forces o to all zeros
//   o    : one-hot select
module onehot_dec #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]      idx,
  input  logic              en_n,
  output logic [(2**N)-1:0] o
);

  localparam int unsigned M = 2 ** N;

  // Reversed mapping: output bit M-1-k tracks index k.
  always_comb begin
    o = '0;
    for (int k = 0; k < M; k++) begin
      o[M-1-k] = (idx == N'(k)) & ~en_n;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// N -> 2^N one-hot select with registered index and an auto-scan sequencer.
//   clk, rst : clock, asynchronous active-high reset
//   en_n     : active-low enable; high blanks o and freezes all sequencing
//   mode     : 00 direct, 01 scan-up, 10 scan-down, 11 single sweep
//   sel      : index loaded every enabled cycle in direct mode
//   start    : sweep launch, honoured only in mode 11 while idle
//   o        : one-hot select (blanked combinationally by en_n)
//   idx      : current registered index
//   busy     : high while a sweep runs
//   wrap     : one-cycle pulse on scan wrap or sweep completion
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int unsigned N   = 2,
  parameter int unsigned DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_n,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      sel,
  input  logic              start,
  output logic [(2**N)-1:0] o,
  output logic [N-1:0]      idx,
  output logic              busy,
  output logic              wrap
);

  localparam int unsigned PW = presc_width(DIV);
  localparam logic [N-1:0] IDX_MAX = '1;

  state_t         state_q, state_d;
  mode_t          mode_q, mode_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           busy_q, busy_d;
  logic           wrap_q, wrap_d;
  logic           active_q, active_d;

  mode_t          mode_in;
  logic           mode_chg;
  logic           step;

  assign mode_in  = mode_t'(mode);
  assign mode_chg = (mode_in != mode_q);
  assign step     = (presc_q == PW'(DIV - 1));

  // State registers. mode_q resets to SWEEP to match reset state IDLE, so
  // mode 11 right after reset is not treated as a mode change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_SWEEP;
      idx_q    <= '0;
      presc_q  <= '0;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      presc_q  <= presc_d;
      busy_q   <= busy_d;
      wrap_q   <= wrap_d;
      active_q <= active_d;
    end
  end

  // Next-state logic; en_n high holds everything (mode_q included, so a mode
  // change made while disabled is acted on once enabled again).
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    presc_d  = presc_q;
    busy_d   = busy_q;
    wrap_d   = 1'b0;
    active_d = active_q;

    if (!en_n) begin
      mode_d = mode_in;
      unique case (mode_in)
        MODE_DIRECT: begin
          state_d  = DIRECT;
          idx_d    = sel;
          presc_d  = '0;
          busy_d   = 1'b0;
          active_d = 1'b1;
        end

        MODE_UP, MODE_DOWN: begin
          state_d  = SCAN;
          busy_d   = 1'b0;
          active_d = 1'b1;
          if (mode_chg) begin
            presc_d = '0;
          end else if (step) begin
            presc_d = '0;
            if (mode_in == MODE_UP) begin
              idx_d  = idx_q + N'(1);
              wrap_d = (idx_q == IDX_MAX);
            end else begin
              idx_d  = idx_q - N'(1);
              wrap_d = (idx_q == '0);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end

        MODE_SWEEP: begin
          if (mode_chg) begin
            // Entering mode 11 (or aborting): park in IDLE without a wrap.
            state_d  = IDLE;
            busy_d   = 1'b0;
            presc_d  = '0;
            active_d = 1'b0;
          end else if (state_q == SWEEP) begin
            if (step) begin
              presc_d = '0;
              if (idx_q == IDX_MAX) begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                wrap_d   = 1'b1;
                idx_d    = '0;
                active_d = 1'b0;
              end else begin
                idx_d = idx_q + N'(1);
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end else if (start) begin
            state_d  = SWEEP;
            idx_d    = '0;
            presc_d  = '0;
            busy_d   = 1'b1;
            active_d = 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

  // Output decode: blanked when inactive or disabled.
  onehot_dec #(
    .N (N)
  ) u_dec (
    .idx  (idx_q),
    .en_n (en_n | ~active_q),
    .o    (o)
  );

  assign idx  = idx_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder (N = 2, DIV = 4) using a scoreboard.
module tb_scan_decoder;

  localparam int unsigned N   = 2;
  localparam int unsigned DIV = 4;
  localparam int unsigned M   = 2 ** N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en_n = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [N-1:0] sel = '0;
  logic         start = 1'b0;
  logic [M-1:0] o;
  logic [N-1:0] idx;
  logic         busy;
  logic         wrap;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int idx;
    int busy;
    int wrap;
    int act;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  int m_mode, m_idx, m_pre, m_busy, m_wrap, m_act;

  scan_decoder #(.N(N), .DIV(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .en_n  (en_n),
    .mode  (mode),
    .sel   (sel),
    .start (start),
    .o     (o),
    .idx   (idx),
    .busy  (busy),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_o(input int i, input int act);
    logic [31:0] v;
    v = 32'd0;
    if (act != 0 && !en_n) v = 32'd1 << (M - 1 - i);
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 3; m_idx = 0; m_pre = 0; m_busy = 0; m_wrap = 0; m_act = 0;
  endtask

  // Behavioural model of one rising edge from the sampled inputs.
  task automatic model_step();
    bit chg;
    m_wrap = 0;
    if (en_n) return;
    chg = (int'(mode) != m_mode);
    m_mode = int'(mode);
    if (mode == 2'b00) begin
      m_idx = int'(sel); m_pre = 0; m_busy = 0; m_act = 1;
    end else if (mode != 2'b11) begin
      m_busy = 0; m_act = 1;
      if (chg) m_pre = 0;
      else if (m_pre == DIV - 1) begin
        m_pre = 0;
        if (mode == 2'b01) begin
          m_wrap = (m_idx == M - 1);
          m_idx  = (m_idx + 1) % M;
        end else begin
          m_wrap = (m_idx == 0);
          m_idx  = (m_idx + M - 1) % M;
        end
      end else m_pre++;
    end else begin
      if (chg) begin
        m_busy = 0; m_act = 0; m_pre = 0;
      end else if (m_busy == 0) begin
        if (start) begin m_busy = 1; m_idx = 0; m_pre = 0; m_act = 1; end
      end else if (m_pre == DIV - 1) begin
        m_pre = 0;
        if (m_idx == M - 1) begin
          m_busy = 0; m_wrap = 1; m_idx = 0; m_act = 0;
        end else m_idx++;
      end else m_pre++;
    end
  endtask

  // One clock: model predicts at the edge, DUT is compared at the falling edge.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_step();
    sb_q.push_back('{idx: m_idx, busy: m_busy, wrap: m_wrap, act: m_act});
    @(negedge clk);
    e = sb_q.pop_front();
    chk("sb_idx",  32'(idx),  32'(e.idx));
    chk("sb_busy", 32'(busy), 32'(e.busy));
    chk("sb_wrap", 32'(wrap), 32'(e.wrap));
    chk("sb_o",    32'(o),    exp_o(e.idx, e.act));
  endtask

  initial begin
    logic [3:0] dir_tab [4];
    int cnt;
    int wraps;
    dir_tab[0] = 4'b1000; dir_tab[1] = 4'b0100;
    dir_tab[2] = 4'b0010; dir_tab[3] = 4'b0001;

    // Asynchronous reset without any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_o",    32'(o),    32'd0);
    chk("rst_idx",  32'(idx),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Direct mode
    mode = 2'b00; en_n = 1'b0;
    for (int s = 0; s < M; s++) begin
      sel = N'(s);
      cycle();
      chk("dir_o", 32'(o), 32'(dir_tab[s]));
      chk("dir_wrap", 32'(wrap), 32'd0);
    end

    // Blanking: combinational, index held
    sel = 2'd2; en_n = 1'b1;
    #1 chk("blank_o", 32'(o), 32'd0);
    repeat (2) cycle();
    chk("blank_idx", 32'(idx), 32'd3);
    en_n = 1'b0;
    #1 chk("unblank_o", 32'(o), 32'(4'b0001));
    cycle();
    chk("dir_after_en", 32'(o), 32'(4'b0010));

    // Scan up, then scan down; one wrap each over 20 cycles
    mode = 2'b01; wraps = 0;
    for (int i = 0; i < 20; i++) begin cycle(); if (wrap) wraps++; end
    chk("up_wraps", 32'(wraps), 32'd1);
    mode = 2'b10; wraps = 0;
    for (int i = 0; i < 20; i++) begin cycle(); if (wrap) wraps++; end
    chk("down_wraps", 32'(wraps), 32'd1);

    // Sweep with a second start mid-way
    mode = 2'b11;
    repeat (2) cycle();
    chk("idle_o", 32'(o), 32'd0);
    start = 1'b1; cycle(); start = 1'b0;
    chk("sw_busy", 32'(busy), 32'd1);
    chk("sw_o0", 32'(o), 32'(4'b1000));
    cnt = 0; wraps = 0;
    while (busy && cnt < 40) begin
      start = (cnt == 7);
      cycle(); cnt++;
      if (wrap) wraps++;
    end
    start = 1'b0;
    chk("sw_len", 32'(cnt), 32'(DIV * M));
    chk("sw_wrap", 32'(wraps), 32'd1);
    chk("sw_end_o", 32'(o), 32'd0);

    // Sweep paused for 5 cycles at idx 2
    start = 1'b1; cycle(); start = 1'b0;
    cnt = 0;
    while (busy && cnt < 60) begin
      cycle(); cnt++;
      if (cnt == 8) begin
        chk("pause_idx", 32'(idx), 32'd2);
        en_n = 1'b1;
      end
      if (cnt == 13) en_n = 1'b0;
    end
    chk("pause_len", 32'(cnt), 32'(DIV * M + 5));

    // Abort via mode change
    start = 1'b1; cycle(); start = 1'b0;
    repeat (5) cycle();
    mode = 2'b00; sel = 2'd1;
    cycle();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wrap", 32'(wrap), 32'd0);

    // Reset mid-scan at idx 3
    mode = 2'b01;
    cnt = 0;
    while ((idx != 2'd3 || cnt < 2) && cnt < 40) begin cycle(); cnt++; end
    chk("pre_rst_idx", 32'(idx), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("mrst_o",    32'(o),    32'd0);
    chk("mrst_idx",  32'(idx),  32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_wrap", 32'(wrap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised N-to-2^N one-hot decoder with registered index, active-low enable and an auto-scan sequencer. It generalises the lab 2-to-4 decoder to any width. It adds direct, free-running scan-up/scan-down and single-sweep modes. Typical use is digit/row select for multiplexed displays and LED matrices in the DD lab designs.

## Interface
- N, default 2, index width; output width is 2^N (N ≥ 1).
- DIV, default 4, clock cycles per scan step (DIV ≥ 1).
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en_n  in  1  active-low enable; high blanks o and freezes sequencing.
- mode  in  2  00 direct, 01 scan-up, 10 scan-down, 11 single sweep.
- sel  in  N  index used in direct mode.
- start  in  1  sweep launch pulse, sampled only in mode 11.
- o  out  2^N  one-hot select; index k asserts o[2^N-1-k] (k=0 drives MSB).
- idx  out  N  current registered index.
- busy  out  1  high while a sweep is in progress.
- wrap  out  1  one-cycle pulse on index wrap or sweep completion.

## Operation
- States: IDLE, DIRECT, SCAN, SWEEP. State follows mode: 00→DIRECT, 01/10→SCAN, 11→IDLE until start, then SWEEP.
- The active flag is registered. o = active & ~en_n ? onehot(idx) : 0. active is 1 in DIRECT/SCAN/SWEEP and 0 in IDLE.
- DIRECT: idx <= sel every enabled cycle; prescaler held at 0; wrap never asserted.
- SCAN: prescaler counts 0..DIV-1.
  - On prescaler = DIV-1, the step fires: idx +1 (mode 01) or −1 (mode 10), modulo 2^N.
  - wrap pulses on the step max→0 (up) or 0→max (down).
- SWEEP: start in IDLE sets idx <= 0, busy <= 1, prescaler <= 0, state SWEEP.
  - Steps up every DIV cycles.
  - The step taken at idx = 2^N-1 ends the sweep: busy <= 0, wrap pulses, idx <= 0, state IDLE (o goes 0).
- start while busy or in modes 00/01/10: ignored.
- en_n high: o = 0 combinationally.
  - idx, prescaler, state and busy hold; wrap = 0.
  - A sweep pauses and resumes on en_n low.
  - start is ignored while en_n is high.
- Mode change, detected against the registered mode:
  - Prescaler clears to 0 and idx is retained.
  - An active sweep aborts: busy <= 0, no wrap pulse, state IDLE.
- DIV = 1: a step fires every enabled cycle.
- Arithmetic: idx is N-bit unsigned with natural wrap; the prescaler is $clog2(DIV)+1 bits.

## Timing
- Reset (async assert, sync-released by system): idx=0, busy=0, wrap=0, prescaler=0, state IDLE, o=0.
- sel → idx/o latency: 1 cycle in DIRECT.
- en_n → o blanking: combinational, 0 cycles. Unblanking shows the held idx on the same cycle.
- In SCAN, idx changes every DIV enabled cycles. A full scan period is DIV·2^N cycles.
- start → busy=1, o=onehot(0): 1 cycle. A sweep lasts DIV·2^N cycles from the start edge to busy low.
- wrap is high in the same cycle idx shows its post-wrap value.
- Reset mid-sweep: all outputs return to reset values immediately; no wrap pulse.

## Structure
- Package scan_decoder_pkg holds:
  - mode_t enum (MODE_DIRECT, MODE_UP, MODE_DOWN, MODE_SWEEP);
  - state_t enum (IDLE, DIRECT, SCAN, SWEEP);
  - a function for the prescaler width.
- Sub-module onehot_dec holds the combinational N→2^N decoder with reversed bit order and an active-low enable input. It replaces the lab decoder and is reusable standalone.
- scan_decoder holds the prescaler, index register, FSM and wrap/busy logic, and instantiates onehot_dec.

## Test plan
- Reset, then mode=00, en_n=0, sel=0,1,2,3 (N=2) → o = 1000, 0100, 0010, 0001 one cycle after each sel; wrap=0.
- Direct mode, en_n=1, sel=2 → o=0000 immediately, idx holds. Then en_n=0 → o=0010 after 1 cycle.
- mode=01, DIV=4 → idx 0,1,2,3,0 changes every 4 cycles; wrap pulses once on 3→0. mode=10 → idx 3,2,1,0,3; wrap on 0→3.
- mode=11, start pulse → busy=1, o=1000 next cycle; o steps to 0001 over 16 cycles; busy low, wrap pulse, o=0000. A second start mid-sweep is ignored.
- Sweep with en_n=1 for 5 cycles at idx=2 → idx holds 2 and o=0000; the sweep resumes and finishes 5 cycles late. A mode change to 00 mid-sweep → busy=0, no wrap.
- Assert rst mid-scan at idx=3 → o=0000, idx=0, busy=0 without waiting for clk.
